// File: rtl/param_reorder_buffer_if.sv
// ==========================================================================
// param_reorder_buffer_if: dispatch / write-back / commit bundle for the ROB
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface param_reorder_buffer_if #(
  parameter int DEPTH     = 64,
  parameter int ALLOC_W   = 2,
  parameter int CMT_W     = 2,
  parameter int WB_PORTS  = 4,
  parameter int PAYLOAD_W = 64,
  parameter int WB_DATA_W = 32
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic                          flush;
  logic                          alloc_req;
  logic [ALLOC_W-1:0]            alloc_valid;
  logic [ALLOC_W*PAYLOAD_W-1:0]  alloc_payload;
  logic [ALLOC_W-1:0]            alloc_exc;
  logic [ALLOC_W-1:0]            alloc_serial;
  logic                          alloc_ready;
  logic [ALLOC_W*PTR_W-1:0]      alloc_ptr;
  logic [WB_PORTS-1:0]           wb_valid;
  logic [WB_PORTS*IDX_W-1:0]     wb_idx;
  logic [WB_PORTS-1:0]           wb_oldest;
  logic [WB_PORTS-1:0]           wb_exc;
  logic [WB_PORTS-1:0]           wb_redirect;
  logic [WB_PORTS*WB_DATA_W-1:0] wb_data;
  logic [WB_PORTS-1:0]           wb_ready;
  logic [CMT_W-1:0]              cmt_valid;
  logic [CMT_W*PAYLOAD_W-1:0]    cmt_payload;
  logic [CMT_W*WB_DATA_W-1:0]    cmt_data;
  logic [CMT_W-1:0]              cmt_exc;
  logic [CMT_W-1:0]              cmt_redirect;
  logic                          cmt_ready;
  logic [PTR_W-1:0]              count;
  logic                          empty;
  logic                          full;

  modport slave (
    input  flush, alloc_req, alloc_valid, alloc_payload, alloc_exc, alloc_serial,
    input  wb_valid, wb_idx, wb_oldest, wb_exc, wb_redirect, wb_data, cmt_ready,
    output alloc_ready, alloc_ptr, wb_ready, cmt_valid, cmt_payload, cmt_data,
    output cmt_exc, cmt_redirect, count, empty, full
  );

  modport master (
    output flush, alloc_req, alloc_valid, alloc_payload, alloc_exc, alloc_serial,
    output wb_valid, wb_idx, wb_oldest, wb_exc, wb_redirect, wb_data, cmt_ready,
    input  alloc_ready, alloc_ptr, wb_ready, cmt_valid, cmt_payload, cmt_data,
    input  cmt_exc, cmt_redirect, count, empty, full
  );
endinterface

`default_nettype wire

// File: rtl/param_reorder_buffer.sv
// ==========================================================================
// param_reorder_buffer: in-order alloc, out-of-order write-back, in-order
// multi-lane commit. Optional ROB_PERF_CNT_EN adds stall/wait counters.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module param_reorder_buffer #(
  parameter int DEPTH     = 64,
  parameter int ALLOC_W   = 2,
  parameter int CMT_W     = 2,
  parameter int WB_PORTS  = 4,
  parameter int PAYLOAD_W = 64,
  parameter int WB_DATA_W = 32
) (
  input wire                    clk,
  input wire                    rst_n,
  param_reorder_buffer_if.slave bus
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_full_stall,
  output logic [31:0]           perf_head_wait
`endif
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [PTR_W-1:0]     r_count;
  logic [DEPTH-1:0]     r_complete;
  logic [DEPTH-1:0]     r_exc;
  logic [DEPTH-1:0]     r_redirect;
  logic [DEPTH-1:0]     r_serial;
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [WB_DATA_W-1:0] r_data    [DEPTH];

  logic                 w_alloc_fire;
  logic [PTR_W-1:0]     w_alloc_cnt;
  logic [IDX_W-1:0]     w_alloc_idx [ALLOC_W];
  logic [IDX_W-1:0]     w_wb_idx    [WB_PORTS];
  logic [WB_PORTS-1:0]  w_wb_fire;
  logic [IDX_W-1:0]     w_cmt_idx   [CMT_W];
  logic [CMT_W-1:0]     w_cmt_valid;
  logic                 w_cmt_fire;
  logic [PTR_W-1:0]     w_cmt_cnt;
  logic                 w_go;

  // Only the registered count is used: a same-cycle commit never frees room.
  assign bus.alloc_ready = !bus.flush && (r_count <= PTR_W'(DEPTH - ALLOC_W));
  assign w_alloc_fire    = bus.alloc_req && bus.alloc_ready;

  for (genvar i = 0; i < ALLOC_W; i++) begin : g_alloc
    logic [PTR_W-1:0] w_ptr;
    assign w_ptr                              = r_tail + PTR_W'(i);
    assign bus.alloc_ptr[i*PTR_W +: PTR_W]    = w_ptr;
    assign w_alloc_idx[i]                     = w_ptr[IDX_W-1:0];
  end

  always_comb begin
    w_alloc_cnt = '0;
    if (w_alloc_fire) begin
      for (int i = 0; i < ALLOC_W; i++) begin
        w_alloc_cnt = w_alloc_cnt + PTR_W'(bus.alloc_valid[i]);
      end
    end
  end

  // During flush every write-back is accepted and silently dropped.
  for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
    assign w_wb_idx[p]     = bus.wb_idx[p*IDX_W +: IDX_W];
    assign bus.wb_ready[p] = bus.flush || !bus.wb_oldest[p] ||
                             (w_wb_idx[p] == r_head[IDX_W-1:0]);
    assign w_wb_fire[p]    = bus.wb_valid[p] && bus.wb_ready[p] && !bus.flush;
  end

  for (genvar i = 0; i < CMT_W; i++) begin : g_cmt
    assign w_cmt_idx[i]                               = r_head[IDX_W-1:0] + IDX_W'(i);
    assign bus.cmt_payload[i*PAYLOAD_W +: PAYLOAD_W]  = r_payload[w_cmt_idx[i]];
    assign bus.cmt_data[i*WB_DATA_W +: WB_DATA_W]     = r_data[w_cmt_idx[i]];
    assign bus.cmt_exc[i]                             = r_exc[w_cmt_idx[i]];
    assign bus.cmt_redirect[i]                        = r_redirect[w_cmt_idx[i]];
  end

  // An exc/redirect/serial entry closes the commit group behind it.
  always_comb begin
    w_cmt_valid = '0;
    w_go        = !bus.flush;
    for (int i = 0; i < CMT_W; i++) begin
      if (w_go && (PTR_W'(i) < r_count) && r_complete[w_cmt_idx[i]] &&
          ((i == 0) || !r_serial[w_cmt_idx[i]])) begin
        w_cmt_valid[i] = 1'b1;
      end
      w_go = w_cmt_valid[i] && !(r_exc[w_cmt_idx[i]] || r_redirect[w_cmt_idx[i]] ||
                                 r_serial[w_cmt_idx[i]]);
    end
  end

  assign bus.cmt_valid = w_cmt_valid;
  assign w_cmt_fire    = bus.cmt_ready && w_cmt_valid[0];

  always_comb begin
    w_cmt_cnt = '0;
    if (w_cmt_fire) begin
      for (int i = 0; i < CMT_W; i++) begin
        w_cmt_cnt = w_cmt_cnt + PTR_W'(w_cmt_valid[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_cmt_cnt;
      r_tail  <= r_tail + w_alloc_cnt;
      r_count <= r_count + w_alloc_cnt - w_cmt_cnt;
    end
  end

  // Later ports overwrite earlier ones, so the highest port wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_complete <= '0;
    end else if (bus.flush) begin
      r_complete <= '0;
    end else begin
      for (int i = 0; i < ALLOC_W; i++) begin
        if (w_alloc_fire && bus.alloc_valid[i]) begin
          r_complete[w_alloc_idx[i]] <= bus.alloc_exc[i];
        end
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if (w_wb_fire[p]) begin
          r_complete[w_wb_idx[p]] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ALLOC_W; i++) begin
      if (w_alloc_fire && bus.alloc_valid[i]) begin
        r_exc[w_alloc_idx[i]]      <= bus.alloc_exc[i];
        r_redirect[w_alloc_idx[i]] <= 1'b0;
        r_serial[w_alloc_idx[i]]   <= bus.alloc_serial[i];
        r_payload[w_alloc_idx[i]]  <= bus.alloc_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (w_wb_fire[p]) begin
        r_exc[w_wb_idx[p]]      <= bus.wb_exc[p];
        r_redirect[w_wb_idx[p]] <= bus.wb_redirect[p];
        r_data[w_wb_idx[p]]     <= bus.wb_data[p*WB_DATA_W +: WB_DATA_W];
      end
    end
  end

  assign bus.count = r_count;
  assign bus.empty = (r_count == '0);
  assign bus.full  = (r_count == PTR_W'(DEPTH));

`ifdef ROB_PERF_CNT_EN
  logic [31:0] r_perf_full_stall;
  logic [31:0] r_perf_head_wait;

  // Counters survive flush; only the async reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_full_stall <= '0;
      r_perf_head_wait  <= '0;
    end else begin
      if (bus.alloc_req && !bus.alloc_ready && !bus.flush && (r_perf_full_stall != '1)) begin
        r_perf_full_stall <= r_perf_full_stall + 32'd1;
      end
      if ((r_count != '0) && !w_cmt_valid[0] && (r_perf_head_wait != '1)) begin
        r_perf_head_wait <= r_perf_head_wait + 32'd1;
      end
    end
  end

  assign perf_full_stall = r_perf_full_stall;
  assign perf_head_wait  = r_perf_head_wait;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_reorder_buffer.sv
// ==========================================================================
// tb_param_reorder_buffer: directed self-checking bench for the reorder buffer
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_param_reorder_buffer;
  localparam int DEPTH = 64;
  localparam int IDX_W = 6;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  param_reorder_buffer_if #(.DEPTH(DEPTH), .ALLOC_W(2), .CMT_W(2), .WB_PORTS(4),
                            .PAYLOAD_W(64), .WB_DATA_W(32)) bus ();

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_full_stall;
  logic [31:0] perf_head_wait;
`endif

  param_reorder_buffer #(.DEPTH(DEPTH), .ALLOC_W(2), .CMT_W(2), .WB_PORTS(4),
                         .PAYLOAD_W(64), .WB_DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_full_stall (perf_full_stall),
    .perf_head_wait  (perf_head_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pay(input int k);
    return {32'hCAFE0000 + 32'(k), 32'(k) ^ 32'h5A5A5A5A};
  endfunction

  function automatic logic [31:0] dat(input int k);
    return 32'hD0000000 + 32'(k);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc2(input int k0, input int k1, input logic [1:0] exc, input logic [1:0] ser);
    bus.alloc_req     = 1'b1;
    bus.alloc_valid   = 2'b11;
    bus.alloc_payload = {pay(k1), pay(k0)};
    bus.alloc_exc     = exc;
    bus.alloc_serial  = ser;
  endtask

  task automatic alloc_off();
    bus.alloc_req    = 1'b0;
    bus.alloc_valid  = '0;
    bus.alloc_exc    = '0;
    bus.alloc_serial = '0;
  endtask

  task automatic wb_set(input int p, input int idx, input logic [31:0] d,
                        input logic rd, input logic old);
    bus.wb_valid[p]              = 1'b1;
    bus.wb_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
    bus.wb_data[p*32 +: 32]      = d;
    bus.wb_exc[p]                = 1'b0;
    bus.wb_redirect[p]           = rd;
    bus.wb_oldest[p]             = old;
  endtask

  task automatic wb_clear();
    bus.wb_valid    = '0;
    bus.wb_idx      = '0;
    bus.wb_data     = '0;
    bus.wb_exc      = '0;
    bus.wb_redirect = '0;
    bus.wb_oldest   = '0;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.flush         = 1'b0;
    bus.cmt_ready     = 1'b0;
    bus.alloc_payload = '0;
    alloc_off();
    wb_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_alloc_ready", bus.alloc_ready, 1);
    check("rst_cmt_valid", bus.cmt_valid, 0);
    rst_n = 1'b1;
    step();

    // Fill all 64 entries two per cycle.
    for (int k = 0; k < 32; k++) begin
      alloc2(2*k, 2*k+1, 2'b00, 2'b00);
      #1;
      check("fill_ready", bus.alloc_ready, 1);
      check("fill_ptr", bus.alloc_ptr, {7'(2*k+1), 7'(2*k)});
      step();
    end
    check("full_ready", bus.alloc_ready, 0);
    check("full_flag", bus.full, 1);
    check("full_count", bus.count, 64);
    check("full_ptr", bus.alloc_ptr[6:0], 7'd64);
    step();
    check("full_hold_count", bus.count, 64);
    alloc_off();

    // Complete only the head entry and commit it alone.
    wb_set(0, 0, dat(0), 1'b0, 1'b1);
    #1;
    check("head_wb_ready", bus.wb_ready[0], 1);
    step();
    wb_clear();
    bus.cmt_ready = 1'b1;
    #1;
    check("single_cmt_valid", bus.cmt_valid, 2'b01);
    check("single_cmt_payload", bus.cmt_payload[63:0], pay(0));
    check("single_cmt_data", bus.cmt_data[31:0], dat(0));
    step();
    bus.cmt_ready = 1'b0;
    bus.alloc_req = 1'b1;
    bus.alloc_valid = 2'b11;
    #1;
    check("c63_count", bus.count, 63);
    check("c63_ready", bus.alloc_ready, 0);
    check("c63_full", bus.full, 0);
    step();
    check("c63_hold", bus.count, 63);
    alloc_off();

    // Asynchronous reset in the middle of operation.
    rst_n = 1'b0;
    #1;
    check("midrst_count", bus.count, 0);
    check("midrst_empty", bus.empty, 1);
    check("midrst_ptr", bus.alloc_ptr[6:0], 0);
    step();
    rst_n = 1'b1;
    step();

    // Out-of-order write-back 3,2,1,0.
    alloc2(100, 101, 2'b00, 2'b00);
    step();
    alloc2(102, 103, 2'b00, 2'b00);
    step();
    alloc_off();
    bus.cmt_ready = 1'b1;
    for (int j = 3; j >= 0; j--) begin
      wb_clear();
      wb_set(1, j, dat(j), 1'b0, 1'b0);
      #1;
      check("ooo_no_commit", bus.cmt_valid, 0);
      step();
    end
    wb_clear();
    #1;
    check("ooo_cmt1_valid", bus.cmt_valid, 2'b11);
    check("ooo_cmt1_payload", bus.cmt_payload, {pay(101), pay(100)});
    check("ooo_cmt1_data", bus.cmt_data, {dat(1), dat(0)});
    step();
    check("ooo_cmt2_valid", bus.cmt_valid, 2'b11);
    check("ooo_cmt2_payload0", bus.cmt_payload[63:0], pay(102));
    check("ooo_cmt2_data1", bus.cmt_data[63:32], dat(3));
    step();
    check("ooo_empty", bus.empty, 1);
    check("ooo_cmt_valid", bus.cmt_valid, 0);

    // Redirect ends the group; colliding write-back ports.
    bus.cmt_ready = 1'b0;
    alloc2(204, 205, 2'b00, 2'b00);
    step();
    alloc2(206, 207, 2'b00, 2'b00);
    step();
    alloc_off();
    wb_set(0, 4, dat(4), 1'b0, 1'b0);
    wb_set(1, 5, dat(5), 1'b1, 1'b0);
    wb_set(2, 6, dat(6), 1'b0, 1'b0);
    step();
    wb_clear();
    wb_set(1, 7, dat(71), 1'b0, 1'b0);
    wb_set(3, 7, dat(73), 1'b0, 1'b0);
    #1;
    check("redir_valid", bus.cmt_valid, 2'b11);
    check("redir_flag", bus.cmt_redirect, 2'b10);
    check("redir_exc", bus.cmt_exc, 2'b00);
    step();
    wb_clear();
    bus.cmt_ready = 1'b1;
    #1;
    check("redir_stable", bus.cmt_valid, 2'b11);
    check("redir_stable_flag", bus.cmt_redirect, 2'b10);
    step();
    check("redir_count_after", bus.count, 2);
    check("redir_next_valid", bus.cmt_valid, 2'b11);
    check("wb_port_priority", bus.cmt_data[63:32], dat(73));
    step();
    check("redir_empty", bus.empty, 1);

    // Oldest-only write-back waits for head.
    bus.cmt_ready = 1'b0;
    alloc2(208, 209, 2'b00, 2'b00);
    step();
    alloc2(210, 211, 2'b00, 2'b00);
    step();
    alloc_off();
    wb_set(0, 10, dat(10), 1'b0, 1'b1);
    wb_set(1, 8, dat(8), 1'b0, 1'b0);
    wb_set(2, 9, dat(9), 1'b0, 1'b0);
    #1;
    check("oldest_ready_a", bus.wb_ready, 4'b1110);
    step();
    bus.wb_valid[1] = 1'b0;
    bus.wb_valid[2] = 1'b0;
    bus.cmt_ready   = 1'b1;
    #1;
    check("oldest_ready_b", bus.wb_ready[0], 0);
    check("oldest_cmt_b", bus.cmt_valid, 2'b11);
    step();
    bus.cmt_ready = 1'b0;
    #1;
    check("oldest_ready_c", bus.wb_ready[0], 1);
    check("oldest_cmt_c", bus.cmt_valid, 0);
    step();
    wb_clear();
    wb_set(0, 11, dat(11), 1'b0, 1'b0);
    #1;
    check("oldest_cmt_d", bus.cmt_valid, 2'b01);
    step();
    wb_clear();
    bus.cmt_ready = 1'b1;
    #1;
    check("oldest_cmt_e", bus.cmt_valid, 2'b11);
    check("oldest_data_e", bus.cmt_data[31:0], dat(10));
    step();
    check("oldest_empty", bus.empty, 1);

    // Front-end exception and serialising entry.
    bus.cmt_ready = 1'b0;
    alloc2(312, 313, 2'b01, 2'b00);
    step();
    alloc_off();
    wb_set(0, 13, dat(13), 1'b0, 1'b0);
    #1;
    check("exc_born_valid", bus.cmt_valid, 2'b01);
    check("exc_born_flag", bus.cmt_exc, 2'b01);
    step();
    wb_clear();
    bus.cmt_ready = 1'b1;
    #1;
    check("exc_alone", bus.cmt_valid, 2'b01);
    step();
    check("exc_next_valid", bus.cmt_valid, 2'b01);
    check("exc_next_flag", bus.cmt_exc[0], 0);
    check("exc_next_payload", bus.cmt_payload[63:0], pay(313));
    step();
    bus.cmt_ready = 1'b0;
    alloc2(314, 315, 2'b00, 2'b10);
    step();
    alloc_off();
    wb_set(0, 14, dat(14), 1'b0, 1'b0);
    wb_set(1, 15, dat(15), 1'b0, 1'b0);
    step();
    wb_clear();
    bus.cmt_ready = 1'b1;
    #1;
    check("serial_block", bus.cmt_valid, 2'b01);
    step();
    check("serial_alone", bus.cmt_valid, 2'b01);
    check("serial_payload", bus.cmt_payload[63:0], pay(315));
    step();
    check("serial_empty", bus.empty, 1);
    bus.cmt_ready = 1'b0;

    // March head to 62.
    for (int h = 16; h < 62; h += 2) begin
      alloc2(h, h + 1, 2'b00, 2'b00);
      step();
      alloc_off();
      wb_set(0, h, dat(h), 1'b0, 1'b0);
      wb_set(1, h + 1, dat(h + 1), 1'b0, 1'b0);
      step();
      wb_clear();
      bus.cmt_ready = 1'b1;
      step();
      bus.cmt_ready = 1'b0;
    end
    check("march_empty", bus.empty, 1);

    // Commit across the wrap point.
    alloc2(462, 463, 2'b00, 2'b00);
    #1;
    check("wrap_ptr_a", bus.alloc_ptr, {7'd63, 7'd62});
    step();
    alloc2(464, 465, 2'b00, 2'b00);
    #1;
    check("wrap_ptr_b", bus.alloc_ptr, {7'd65, 7'd64});
    step();
    alloc_off();
    wb_set(0, 62, dat(62), 1'b0, 1'b0);
    wb_set(1, 63, dat(63), 1'b0, 1'b0);
    wb_set(2, 0, dat(0), 1'b0, 1'b0);
    wb_set(3, 1, dat(1), 1'b0, 1'b0);
    step();
    wb_clear();
    bus.cmt_ready = 1'b1;
    #1;
    check("wrap_count", bus.count, 4);
    check("wrap_cmt1", bus.cmt_payload, {pay(463), pay(462)});
    step();
    check("wrap_cmt2_valid", bus.cmt_valid, 2'b11);
    check("wrap_cmt2", bus.cmt_payload, {pay(465), pay(464)});
    step();
    check("wrap_empty", bus.empty, 1);
    check("wrap_tail", bus.alloc_ptr[6:0], 7'd66);
    bus.cmt_ready = 1'b0;

    // Flush with ten entries in flight.
    for (int k = 0; k < 5; k++) begin
      alloc2(500 + 2*k, 501 + 2*k, 2'b00, 2'b00);
      step();
    end
    alloc_off();
    wb_set(0, 2, dat(2), 1'b0, 1'b0);
    wb_set(1, 3, dat(3), 1'b0, 1'b0);
    step();
    wb_clear();
    bus.flush     = 1'b1;
    bus.cmt_ready = 1'b1;
    bus.alloc_req = 1'b1;
    bus.alloc_valid = 2'b11;
    wb_set(2, 5, dat(5), 1'b0, 1'b1);
    #1;
    check("flush_count_before", bus.count, 10);
    check("flush_cmt_valid", bus.cmt_valid, 0);
    check("flush_alloc_ready", bus.alloc_ready, 0);
    check("flush_wb_ready", bus.wb_ready, 4'b1111);
    step();
    bus.flush     = 1'b0;
    bus.cmt_ready = 1'b0;
    alloc_off();
    wb_clear();
    #1;
    check("flush_count_after", bus.count, 0);
    check("flush_empty", bus.empty, 1);
    check("flush_ptr", bus.alloc_ptr[6:0], 0);
    check("flush_cmt_after", bus.cmt_valid, 0);
    step();
    check("flush_hold", bus.count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
